// File: rtl/trig_mon_pkg.sv
// Shared types and constants for the trigger interval monitor.
package trig_mon_pkg;

    localparam int unsigned DEF_INT_BITS = 36;
    localparam int unsigned DEF_FIFO_AW  = 4;

    // Wide all-ones; users slice it down to their counter width (INT_BITS <= 64).
    localparam logic [63:0] INT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_RUN
    } state_e;

endpackage

// File: rtl/trig_mon_fifo.sv
// First-word-fall-through FIFO; head is presented combinationally and reads as 0 when empty.
module trig_mon_fifo #(
    parameter int unsigned INT_BITS = 36,
    parameter int unsigned FIFO_AW  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr,
    input  logic [INT_BITS-1:0] din,
    input  logic                rd,
    input  logic                clr,
    output logic [INT_BITS-1:0] dout,
    output logic                empty,
    output logic                full
);

    localparam int unsigned Depth = 1 << FIFO_AW;

    logic [INT_BITS-1:0] mem_q [Depth];
    logic [FIFO_AW-1:0]  wptr_q, rptr_q;
    logic [FIFO_AW:0]    cnt_q;
    logic                do_wr, do_rd;

    assign empty = (cnt_q == '0);
    assign full  = cnt_q[FIFO_AW];
    // A pop in the same cycle frees the slot, so a write into a full FIFO is still accepted.
    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);
    assign dout  = empty ? '0 : mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + FIFO_AW'(1);
            if (do_rd) rptr_q <= rptr_q + FIFO_AW'(1);
            unique case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + (FIFO_AW + 1)'(1);
                2'b01:   cnt_q <= cnt_q - (FIFO_AW + 1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem_q[wptr_q] <= din;
    end

endmodule

// File: rtl/trig_interval_monitor.sv
// Measures CLK-cycle intervals between rising TRIG edges and queues them for readout.
// Define TRIG_MON_MINMAX_EN to add MIN_INTERVAL / MAX_INTERVAL tracking.
module trig_interval_monitor
    import trig_mon_pkg::*;
#(
    parameter int unsigned INT_BITS = DEF_INT_BITS,
    parameter int unsigned FIFO_AW  = DEF_FIFO_AW
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                ENABLE,
    input  logic                CLR,
    input  logic                TRIG,
    input  logic                RD,
    output logic [INT_BITS-1:0] INTERVAL,
    output logic                VALID,
    output logic [31:0]         TRIG_COUNT,
    output logic                OVERFLOW
`ifdef TRIG_MON_MINMAX_EN
    ,
    output logic [INT_BITS-1:0] MIN_INTERVAL,
    output logic [INT_BITS-1:0] MAX_INTERVAL
`endif
);

    localparam logic [INT_BITS-1:0] CntMax = INT_MAX[INT_BITS-1:0];

    state_e              state_q;
    logic [INT_BITS-1:0] cnt_q;
    logic [31:0]         tc_q;
    logic                ovf_q;
    logic                trig_q;
    logic                trig_edge;
    logic                run_edge;
    logic                fifo_empty, fifo_full;
    logic                drop;

    assign trig_edge = TRIG & ~trig_q;
    assign run_edge  = (state_q == ST_RUN) & ENABLE & trig_edge & ~CLR;
    // Full is only relieved by a same-cycle pop; full implies non-empty, so RD alone decides.
    assign drop      = run_edge & fifo_full & ~RD;

    trig_mon_fifo #(
        .INT_BITS(INT_BITS),
        .FIFO_AW (FIFO_AW)
    ) u_fifo (
        .clk  (CLK),
        .rst  (RESET),
        .wr   (run_edge),
        .din  (cnt_q),
        .rd   (RD),
        .clr  (CLR),
        .dout (INTERVAL),
        .empty(fifo_empty),
        .full (fifo_full)
    );

    assign VALID      = ~fifo_empty;
    assign TRIG_COUNT = tc_q;
    assign OVERFLOW   = ovf_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tc_q    <= '0;
            ovf_q   <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            trig_q <= TRIG;
            if (CLR) begin
                state_q <= ENABLE ? ST_ARMED : ST_IDLE;
                cnt_q   <= '0;
                tc_q    <= '0;
                ovf_q   <= 1'b0;
            end else if (!ENABLE) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_ARMED;
                        cnt_q   <= '0;
                    end
                    ST_ARMED: begin
                        if (trig_edge) begin
                            state_q <= ST_RUN;
                            cnt_q   <= INT_BITS'(1);
                            tc_q    <= tc_q + 32'd1;
                        end
                    end
                    ST_RUN: begin
                        if (trig_edge) begin
                            cnt_q <= INT_BITS'(1);
                            tc_q  <= tc_q + 32'd1;
                            if (drop) ovf_q <= 1'b1;
                        end else if (cnt_q != CntMax) begin
                            cnt_q <= cnt_q + INT_BITS'(1);
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

`ifdef TRIG_MON_MINMAX_EN
    logic [INT_BITS-1:0] min_q, max_q;

    // Tracks every RUN-state interval, including ones dropped by a full FIFO.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            min_q <= CntMax;
            max_q <= '0;
        end else if (CLR) begin
            min_q <= CntMax;
            max_q <= '0;
        end else if (run_edge) begin
            if (cnt_q < min_q) min_q <= cnt_q;
            if (cnt_q > max_q) max_q <= cnt_q;
        end
    end

    assign MIN_INTERVAL = min_q;
    assign MAX_INTERVAL = max_q;
`endif

endmodule

// File: tb/tb_trig_interval_monitor.sv
// Scoreboard bench for trig_interval_monitor: expected intervals are queued at each driven rise.
module tb_trig_interval_monitor;

    localparam int unsigned W  = 36;
    localparam int unsigned W8 = 8;

    logic         CLK;
    logic         RESET, ENABLE, CLR, TRIG, RD;
    logic [W-1:0] INTERVAL;
    logic         VALID, OVERFLOW;
    logic [31:0]  TRIG_COUNT;

    logic          rst8, en8, clr8, trig8, rd8;
    logic [W8-1:0] interval8;
    logic          valid8, ovf8;
    logic [31:0]   tc8;

`ifdef TRIG_MON_MINMAX_EN
    logic [W-1:0]  MIN_INTERVAL, MAX_INTERVAL;
    logic [W8-1:0] min8, max8;
`endif

    trig_interval_monitor dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE    (ENABLE),
        .CLR       (CLR),
        .TRIG      (TRIG),
        .RD        (RD),
        .INTERVAL  (INTERVAL),
        .VALID     (VALID),
        .TRIG_COUNT(TRIG_COUNT),
        .OVERFLOW  (OVERFLOW)
`ifdef TRIG_MON_MINMAX_EN
        ,
        .MIN_INTERVAL(MIN_INTERVAL),
        .MAX_INTERVAL(MAX_INTERVAL)
`endif
    );

    trig_interval_monitor #(.INT_BITS(W8), .FIFO_AW(4)) dut8 (
        .CLK       (CLK),
        .RESET     (rst8),
        .ENABLE    (en8),
        .CLR       (clr8),
        .TRIG      (trig8),
        .RD        (rd8),
        .INTERVAL  (interval8),
        .VALID     (valid8),
        .TRIG_COUNT(tc8),
        .OVERFLOW  (ovf8)
`ifdef TRIG_MON_MINMAX_EN
        ,
        .MIN_INTERVAL(min8),
        .MAX_INTERVAL(max8)
`endif
    );

    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;
    longint       cyc   = 0;
    longint       last_rise;
    bit           have_prev;
    bit           ovf_exp;
    int unsigned  tc_exp;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] junk;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic tick();
        @(negedge CLK);
    endtask

    // Raise TRIG now and record what the monitor must produce for this edge.
    task automatic mark_rise();
        TRIG = 1'b1;
        if (have_prev) begin
            if (exp_q.size() < 16) exp_q.push_back(W'(cyc - last_rise));
            else ovf_exp = 1'b1;
        end
        last_rise = cyc;
        have_prev = 1'b1;
        tc_exp++;
    endtask

    task automatic rise(input int high, input int low);
        mark_rise();
        repeat (high) tick();
        TRIG = 1'b0;
        repeat (low) tick();
    endtask

    task automatic do_clear();
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        exp_q.delete();
        have_prev = 1'b0;
        ovf_exp   = 1'b0;
        tc_exp    = 0;
        tick();
    endtask

    task automatic drain(input string name);
        while (exp_q.size() > 0) begin
            n_cmp++;
            if (VALID !== 1'b1 || INTERVAL !== exp_q[0]) begin
                n_err++;
                $display("FAIL %s head: got valid=%0b interval=%0d, want valid=1 interval=%0d",
                         name, VALID, INTERVAL, exp_q[0]);
            end
            junk = exp_q.pop_front();
            RD = 1'b1;
            tick();
            RD = 1'b0;
        end
        n_cmp++;
        if (VALID !== 1'b0) begin
            n_err++;
            $display("FAIL %s empty: got valid=%0b, want 0", name, VALID);
        end
    endtask

    task automatic check_counts(input string name);
        n_cmp++;
        if (TRIG_COUNT !== tc_exp || OVERFLOW !== ovf_exp) begin
            n_err++;
            $display("FAIL %s counts: got count=%0d ovf=%0b, want count=%0d ovf=%0b",
                     name, TRIG_COUNT, OVERFLOW, tc_exp, ovf_exp);
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1; ENABLE = 1'b0; CLR = 1'b0; TRIG = 1'b0; RD = 1'b0;
        rst8 = 1'b1; en8 = 1'b0; clr8 = 1'b0; trig8 = 1'b0; rd8 = 1'b0;
        repeat (3) tick();
        n_cmp++;
        if (VALID !== 1'b0 || INTERVAL !== '0 || TRIG_COUNT !== '0 || OVERFLOW !== 1'b0) begin
            n_err++;
            $display("FAIL reset: got valid=%0b interval=%0d count=%0d ovf=%0b, want all 0",
                     VALID, INTERVAL, TRIG_COUNT, OVERFLOW);
        end
`ifdef TRIG_MON_MINMAX_EN
        n_cmp++;
        if (MIN_INTERVAL !== {W{1'b1}} || MAX_INTERVAL !== '0) begin
            n_err++;
            $display("FAIL reset minmax: got min=%0h max=%0h, want min=all-ones max=0",
                     MIN_INTERVAL, MAX_INTERVAL);
        end
`endif
        RESET = 1'b0;
        rst8  = 1'b0;
        have_prev = 1'b0; ovf_exp = 1'b0; tc_exp = 0;
        tick();
    endtask

    task automatic test_periodic();
        ENABLE = 1'b1;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) rise(3, 4997);
        check_counts("periodic");
        drain("periodic");
    endtask

    task automatic test_held_high();
        do_clear();
        rise(50, 150);
        rise(3, 5);
        n_cmp++;
        if (exp_q.size() != 1 || exp_q[0] !== W'(200)) begin
            n_err++;
            $display("FAIL held_high model: got %0d entries, want one entry of 200", exp_q.size());
        end
        check_counts("held_high");
        drain("held_high");
    endtask

    task automatic test_overflow();
        do_clear();
        for (int i = 0; i < 18; i++) rise(3, 7);
        tick();
        check_counts("overflow");
        drain("overflow");
        RD = 1'b1;
        tick();
        RD = 1'b0;
        n_cmp++;
        if (VALID !== 1'b0 || INTERVAL !== '0) begin
            n_err++;
            $display("FAIL rd_empty: got valid=%0b interval=%0d, want valid=0 interval=0",
                     VALID, INTERVAL);
        end
        // A fresh push after the empty read must land at the head.
        rise(3, 7);
        check_counts("rd_empty_push");
        drain("rd_empty_push");
    endtask

    task automatic test_back_to_back_full_rd();
        do_clear();
        for (int i = 0; i < 17; i++) rise(3, 7);
        check_counts("full_fill");
        n_cmp++;
        if (VALID !== 1'b1 || INTERVAL !== exp_q[0]) begin
            n_err++;
            $display("FAIL full_rd head: got valid=%0b interval=%0d, want valid=1 interval=%0d",
                     VALID, INTERVAL, exp_q[0]);
        end
        RD = 1'b1;
        junk = exp_q.pop_front();
        mark_rise();
        tick();
        RD = 1'b0;
        repeat (2) tick();
        TRIG = 1'b0;
        repeat (3) tick();
        check_counts("full_rd");
        n_cmp++;
        if (exp_q.size() != 16) begin
            n_err++;
            $display("FAIL full_rd model: got %0d queued, want 16", exp_q.size());
        end
        drain("full_rd");
    endtask

    task automatic test_clear();
        rise(3, 7);
        rise(3, 7);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        exp_q.delete(); have_prev = 1'b0; ovf_exp = 1'b0; tc_exp = 0;
        n_cmp++;
        if (VALID !== 1'b0 || TRIG_COUNT !== '0 || OVERFLOW !== 1'b0) begin
            n_err++;
            $display("FAIL clear: got valid=%0b count=%0d ovf=%0b, want 0 0 0",
                     VALID, TRIG_COUNT, OVERFLOW);
        end
        // First edge after the clear arms only; the second produces one interval.
        rise(3, 9);
        rise(3, 3);
        check_counts("clear_rearm");
        drain("clear_rearm");
    endtask

`ifdef TRIG_MON_MINMAX_EN
    task automatic test_minmax();
        do_clear();
        rise(3, 47);
        rise(3, 17);
        rise(3, 87);
        rise(3, 3);
        n_cmp++;
        if (MIN_INTERVAL !== W'(20) || MAX_INTERVAL !== W'(90)) begin
            n_err++;
            $display("FAIL minmax: got min=%0d max=%0d, want min=20 max=90",
                     MIN_INTERVAL, MAX_INTERVAL);
        end
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        exp_q.delete(); have_prev = 1'b0; ovf_exp = 1'b0; tc_exp = 0;
        n_cmp++;
        if (MIN_INTERVAL !== {W{1'b1}} || MAX_INTERVAL !== '0 || TRIG_COUNT !== '0) begin
            n_err++;
            $display("FAIL minmax_clr: got min=%0h max=%0d count=%0d, want all-ones 0 0",
                     MIN_INTERVAL, MAX_INTERVAL, TRIG_COUNT);
        end
    endtask
`endif

    task automatic test_saturate_reset();
        en8 = 1'b1;
        repeat (2) tick();
        trig8 = 1'b1;
        repeat (3) tick();
        trig8 = 1'b0;
        repeat (297) tick();
        trig8 = 1'b1;
        repeat (3) tick();
        trig8 = 1'b0;
        n_cmp++;
        if (valid8 !== 1'b1 || interval8 !== 8'd255 || tc8 !== 32'd2) begin
            n_err++;
            $display("FAIL saturate: got valid=%0b interval=%0d count=%0d, want 1 255 2",
                     valid8, interval8, tc8);
        end
        repeat (20) tick();
        rst8 = 1'b1;
        #1;
        n_cmp++;
        if (valid8 !== 1'b0 || interval8 !== '0 || tc8 !== '0 || ovf8 !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: got valid=%0b interval=%0d count=%0d ovf=%0b, want 0",
                     valid8, interval8, tc8, ovf8);
        end
`ifdef TRIG_MON_MINMAX_EN
        n_cmp++;
        if (min8 !== 8'hff || max8 !== 8'h00) begin
            n_err++;
            $display("FAIL async_reset minmax: got min=%0h max=%0h, want ff 00", min8, max8);
        end
`endif
        tick();
        rst8 = 1'b0;
        en8  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_held_high();
        test_overflow();
        test_back_to_back_full_rd();
        test_clear();
`ifdef TRIG_MON_MINMAX_EN
        test_minmax();
`endif
        test_saturate_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
